data_mem_hs: RTL

//   Byte-addressed, word-organised data memory for the RISC-V core's MEM stage.

---
 rtl/data_mem_hs.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_hs.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_hs
//  Purpose  : Byte-addressed, word-organised data memory with RISC-V load/store
//             widths, valid/ready handshake, programmable latency and faults.
//  Revision : 1.0
// ============================================================================
module data_mem_hs #(
  parameter int AW      = 12,
  parameter int LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [2:0]  i_req_width,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_fault
);

  localparam int DEPTH = 2 ** AW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] c_cnt_init = 4'(LATENCY - 1);

  localparam logic [2:0] c_w_b  = 3'b000;
  localparam logic [2:0] c_w_h  = 3'b001;
  localparam logic [2:0] c_w_w  = 3'b010;
  localparam logic [2:0] c_w_bu = 3'b100;
  localparam logic [2:0] c_w_hu = 3'b101;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic [31:0] mem_q [DEPTH];

  logic          accept;
  logic          addr_hi_bad;
  logic          width_bad;
  logic          align_bad;
  logic          req_fault;
  logic [1:0]    lane;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   ld_data;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_sh;
  logic          wr_en;

  assign accept   = i_req_valid && (state_q == S_IDLE);
  assign lane     = i_req_addr[1:0];
  assign word_idx = i_req_addr[AW+1:2];

  // Addresses above the array must fault rather than alias onto a lower word.
  generate
    if (AW + 2 < 32) begin : g_hi_chk
      assign addr_hi_bad = |i_req_addr[31:AW+2];
    end else begin : g_no_hi_chk
      assign addr_hi_bad = 1'b0;
    end
  endgenerate

  always_comb begin
    width_bad = 1'b0;
    align_bad = 1'b0;
    byte_en   = 4'b0000;
    case (i_req_width)
      c_w_b, c_w_bu: byte_en = 4'b0001 << lane;
      c_w_h, c_w_hu: begin
        align_bad = lane[0];
        byte_en   = 4'b0011 << lane;
      end
      c_w_w: begin
        align_bad = |lane;
        byte_en   = 4'b1111;
      end
      default: width_bad = 1'b1;
    endcase
  end

  assign req_fault = addr_hi_bad || width_bad || align_bad;
  assign wdata_sh  = i_req_wdata << {lane, 3'b000};
  assign wr_en     = accept && i_req_we && !req_fault;

  assign rd_word  = mem_q[word_idx];
  assign rd_shift = rd_word >> {lane, 3'b000};

  always_comb begin
    ld_data = 32'd0;
    case (i_req_width)
      c_w_b:   ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      c_w_bu:  ld_data = {24'd0, rd_shift[7:0]};
      c_w_h:   ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      c_w_hu:  ld_data = {16'd0, rd_shift[15:0]};
      c_w_w:   ld_data = rd_word;
      default: ld_data = 32'd0;
    endcase
  end

  // Storage is deliberately left out of reset so contents survive i_rst_n.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && byte_en[b]) begin
        mem_q[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          fault_d = req_fault;
          rdata_d = (req_fault || i_req_we) ? 32'd0 : ld_data;
          cnt_d   = c_cnt_init;
          state_d = (LATENCY <= 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign o_req_ready = (state_q == S_IDLE);
  assign o_rsp_valid = (state_q == S_RESP);
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_fault = fault_q;

endmodule
`default_nettype wire
